lcd_rgb_timing_gen: RTL and testbench
=====================================

Name: lcd_rgb_timing_gen

Overview:
- Parametrised RGB-interface LCD timing generator with a pixel-fetch handshake.
- Derives a pixel clock enable from clk_50mhz and generates dotclk, hsync, vsync, data_en and an 18-bit bus.
- Pulls pixel data from an external source (sprite/framebuffer logic) at a fixed latency and can draw a white border.
- Has run/graceful-stop control so the panel is never left mid-frame; replaces the fixed 320x480 hard-coded timing logic.

Parameters:
- CLK_DIV, 4, clk_50mhz cycles per pixel; power of two, >=4.
- PIX_LAT, 1, clk cycles from pix_req to pix_data valid; 1..CLK_DIV-2.
- H_SYNC, 30, hsync width in pixels.
- H_BP, 29, horizontal back porch in pixels.
- H_ACT, 320, active pixels per line.
- H_FP, 29, horizontal front porch in pixels.
- V_SYNC, 8, vsync width in lines.
- V_BP, 7, vertical back porch in lines.
- V_ACT, 480, active lines.
- V_FP, 7, vertical front porch in lines.
- HS_POL, 0, hsync active level (0 = active-low).
- VS_POL, 0, vsync active level.
- POS_W, 10, counter/coordinate width; H and V totals must each be <= 2^POS_W.

Ports:
- clk_50mhz  in  1  system clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  run request
- border_en  in  1  draw 18'h3FFFF on first/last active row and column
- pix_req  out  1  pixel fetch strobe
- pix_x  out  POS_W  active-area column for pix_req
- pix_y  out  POS_W  active-area row for pix_req
- pix_data  in  18  pixel from source, valid PIX_LAT cycles after pix_req
- lcd_dotclk  out  1  pixel clock to panel
- lcd_hsync  out  1  horizontal sync
- lcd_vsync  out  1  vertical sync
- lcd_data_en  out  1  active-area strobe
- lcd_db  out  18  pixel bus
- frame_start  out  1  one-cycle pulse at pixel (0,0)
- line_start  out  1  one-cycle pulse at hpos==0
- running  out  1  state is RUN or STOPPING

Behaviour:
- Reset values:
  - state IDLE; phase=0, hpos=0, vpos=0.
  - lcd_dotclk=0, lcd_data_en=0, lcd_db=0.
  - lcd_hsync=~HS_POL, lcd_vsync=~VS_POL.
  - pix_req=0, frame_start=0, line_start=0, running=0.
  - rst mid-frame forces all of these on the next edge.
- IDLE:
  - phase, hpos and vpos are held at 0; outputs stay at reset values.
  - enable=1 moves to RUN on the next edge; the first RUN cycle is phase 0 of pixel (0,0).
- RUN:
  - phase counts 0..CLK_DIV-1.
  - On the edge ending phase CLK_DIV-1, hpos increments; it wraps at H_TOTAL-1 (H_TOTAL = H_SYNC+H_BP+H_ACT+H_FP).
  - vpos increments on the hpos wrap and wraps at V_TOTAL-1.
  - enable=0 moves to STOPPING.
- STOPPING:
  - Identical to RUN.
  - enable=1 returns to RUN with no timing disturbance.
  - If the position wraps to (0,0), go to IDLE instead; no frame_start is issued for that frame.
- Pulses:
  - frame_start=1 during phase 0 of (0,0) in RUN only.
  - line_start=1 during phase 0 of any hpos==0 in RUN/STOPPING.
- Pixel fetch:
  - Active area is hpos in [H_SYNC+H_BP, +H_ACT) and vpos in [V_SYNC+V_BP, +V_ACT).
  - pix_req=1 during phase 0 of every active pixel; otherwise 0.
  - pix_x=hpos-(H_SYNC+H_BP) and pix_y=vpos-(V_SYNC+V_BP), valid while pix_req=1. Both are driven from registered state only.
  - pix_data is sampled on the edge ending phase PIX_LAT.
- LCD outputs (all registered):
  - They update together on the edge ending phase PIX_LAT, for the pixel at the current hpos/vpos.
  - lcd_hsync is active iff hpos<H_SYNC; lcd_vsync is active iff vpos<V_SYNC.
  - lcd_data_en=1 iff the pixel is active.
  - lcd_db priority:
    1. border_en and active and (first/last active column or row): 18'h3FFFF.
    2. Active: pix_data.
    3. Otherwise: 0.
  - border_en is sampled per pixel.
- Dotclk:
  - lcd_dotclk rises on the edge ending phase PIX_LAT+1, giving 1 clk of setup.
  - It falls on the edge ending phase (PIX_LAT+1+CLK_DIV/2) mod CLK_DIV.
  - Duty is 50%; it is held 0 in IDLE.
- Entering IDLE from STOPPING: outputs return to reset values on the same edge; no partial dotclk pulse is allowed.

Test Plan (bench parameters: H 2/2/4/3 (total 11), V 1/1/3/1 (total 6), CLK_DIV=4, PIX_LAT=1; frame = 264 clk):
- Idle: rst, then enable=0 for 300 clk -> all outputs at reset values; pix_req never asserted; lcd_dotclk constant 0.
- Timing: enable=1 held -> frame_start every 264 clk; line_start every 44 clk; hsync low 8 clk/line; vsync low 44 clk/frame; data_en high 16 clk on each of lines 2-4 only; dotclk period 4 clk.
- Pipeline: source returns {pix_y[8:0],pix_x[8:0]} one clk after pix_req, border_en=0 -> lcd_db sequence (0,0),(1,0)..(3,2) while data_en=1; each lcd_db change precedes a dotclk rise by exactly 1 clk.
- Border: border_en=1 -> lcd_db=3FFFF for y=0, y=2, x=0, x=3; (1,1)=0x00201 and (2,1)=0x00202 from the source.
- Graceful stop: drop enable at vpos=3 -> running stays 1 until the wrap, then IDLE exactly at (0,0) with no frame_start; reassert during STOPPING -> next frame_start 264 clk after the previous one.
- Reset mid-frame: rst during an active pixel -> next edge all outputs at reset values, pix_req=0; after release with enable=1, frame_start occurs 1 clk later.

Source files
------------

// File: rtl/lcd_rgb_timing_gen.sv
// lcd_rgb_timing_gen: parametrised RGB LCD timing generator with pixel-fetch handshake and graceful stop
module lcd_rgb_timing_gen #(
  parameter int CLK_DIV = 4,
  parameter int PIX_LAT = 1,
  parameter int H_SYNC  = 30,
  parameter int H_BP    = 29,
  parameter int H_ACT   = 320,
  parameter int H_FP    = 29,
  parameter int V_SYNC  = 8,
  parameter int V_BP    = 7,
  parameter int V_ACT   = 480,
  parameter int V_FP    = 7,
  parameter int HS_POL  = 0,
  parameter int VS_POL  = 0,
  parameter int POS_W   = 10
) (
  input  logic             clk_50mhz,
  input  logic             rst,
  input  logic             enable,
  input  logic             border_en,
  output logic             pix_req,
  output logic [POS_W-1:0] pix_x,
  output logic [POS_W-1:0] pix_y,
  input  logic [17:0]      pix_data,
  output logic             lcd_dotclk,
  output logic             lcd_hsync,
  output logic             lcd_vsync,
  output logic             lcd_data_en,
  output logic [17:0]      lcd_db,
  output logic             frame_start,
  output logic             line_start,
  output logic             running
);
  localparam int PW = $clog2(CLK_DIV);
  localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;
  localparam int H_A0 = H_SYNC + H_BP;
  localparam int V_A0 = V_SYNC + V_BP;
  localparam int RISE = PIX_LAT + 1;
  localparam int FALL = (PIX_LAT + 1 + CLK_DIV / 2) % CLK_DIV;
  localparam logic HS_ACT = 1'(HS_POL);
  localparam logic VS_ACT = 1'(VS_POL);
  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;
  state_t state, state_nxt;
  logic [PW-1:0] phase;
  logic [POS_W-1:0] hpos, vpos;
  int ph, hx, vy;
  logic last_ph, h_last, v_last, wrap, act, edge_px, stop_cut;
  always_comb begin
    ph = int'(phase);
    hx = int'(hpos);
    vy = int'(vpos);
    last_ph = ph == CLK_DIV - 1;
    h_last = hx == H_TOTAL - 1;
    v_last = vy == V_TOTAL - 1;
    wrap = last_ph && h_last && v_last;
    act = hx >= H_A0 && hx < H_A0 + H_ACT && vy >= V_A0 && vy < V_A0 + V_ACT;
    edge_px = hx == H_A0 || hx == H_A0 + H_ACT - 1 || vy == V_A0 || vy == V_A0 + V_ACT - 1;
    stop_cut = state == STOPPING && !enable && h_last && v_last && FALL < RISE;
    state_nxt = state == IDLE ? (enable ? RUN : IDLE) :
                (state == STOPPING && wrap && !enable) ? IDLE :
                enable ? RUN : STOPPING;
  end
  always_ff @(posedge clk_50mhz) begin
    state <= rst ? IDLE : state_nxt;
    if (rst || state == IDLE) begin
      phase <= '0;
      hpos <= '0;
      vpos <= '0;
    end else begin
      phase <= phase + 1'b1;
      if (last_ph) hpos <= h_last ? '0 : hpos + 1'b1;
      if (last_ph && h_last) vpos <= v_last ? '0 : vpos + 1'b1;
    end
  end
  always_ff @(posedge clk_50mhz) begin
    if (rst || state == IDLE || state_nxt == IDLE) begin
      lcd_dotclk <= 1'b0;
      lcd_data_en <= 1'b0;
      lcd_db <= '0;
      lcd_hsync <= ~HS_ACT;
      lcd_vsync <= ~VS_ACT;
    end else begin
      if (ph == PIX_LAT) begin
        lcd_hsync <= hx < H_SYNC ? HS_ACT : ~HS_ACT;
        lcd_vsync <= vy < V_SYNC ? VS_ACT : ~VS_ACT;
        lcd_data_en <= act;
        lcd_db <= !act ? '0 : (border_en && edge_px) ? 18'h3FFFF : pix_data;
      end
      if (ph == RISE && !stop_cut) lcd_dotclk <= 1'b1;
      else if (ph == FALL) lcd_dotclk <= 1'b0;
    end
  end
  assign running = state != IDLE;
  assign pix_req = running && ph == 0 && act;
  assign line_start = running && ph == 0 && hx == 0;
  assign frame_start = state == RUN && ph == 0 && hx == 0 && vy == 0;
  assign pix_x = hpos - POS_W'(H_A0);
  assign pix_y = vpos - POS_W'(V_A0);
endmodule

// File: tb/tb_lcd_rgb_timing_gen.sv
// tb_lcd_rgb_timing_gen: directed checks of timing, pixel pipeline, border, graceful stop and reset
module tb_lcd_rgb_timing_gen;
  logic clk_50mhz = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic border_en = 1'b0;
  logic pix_req;
  logic [9:0] pix_x, pix_y;
  logic [17:0] pix_data = '0;
  logic lcd_dotclk, lcd_hsync, lcd_vsync, lcd_data_en;
  logic [17:0] lcd_db;
  logic frame_start, line_start, running;
  int passed = 0;
  int total = 0;
  lcd_rgb_timing_gen #(
    .CLK_DIV(4), .PIX_LAT(1),
    .H_SYNC(2), .H_BP(2), .H_ACT(4), .H_FP(3),
    .V_SYNC(1), .V_BP(1), .V_ACT(3), .V_FP(1),
    .HS_POL(0), .VS_POL(0), .POS_W(10)
  ) dut (
    .clk_50mhz(clk_50mhz), .rst(rst), .enable(enable), .border_en(border_en),
    .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
    .lcd_dotclk(lcd_dotclk), .lcd_hsync(lcd_hsync), .lcd_vsync(lcd_vsync),
    .lcd_data_en(lcd_data_en), .lcd_db(lcd_db),
    .frame_start(frame_start), .line_start(line_start), .running(running)
  );
  always #10 clk_50mhz = ~clk_50mhz;
  always @(posedge clk_50mhz) if (pix_req) pix_data <= {pix_y[8:0], pix_x[8:0]};
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  function automatic logic rst_vals();
    return lcd_dotclk === 1'b0 && lcd_data_en === 1'b0 && lcd_db === 18'h0 &&
           lcd_hsync === 1'b1 && lcd_vsync === 1'b1 && pix_req === 1'b0 &&
           frame_start === 1'b0 && line_start === 1'b0 && running === 1'b0;
  endfunction
  initial begin
    int bad, req1, dot1;
    int nfs, nls, hs_lo, vs_lo, de, rises, ncap;
    int bad_fs, bad_ls, bad_de, bad_dot, bad_db, run_bad, fs_bad;
    logic pdot;
    logic [17:0] pdb;
    logic [17:0] cap [36];
    logic [17:0] exp_db;
    repeat (3) @(negedge clk_50mhz);
    chk("rst_dotclk", 32'(lcd_dotclk), 0);
    chk("rst_data_en", 32'(lcd_data_en), 0);
    chk("rst_db", 32'(lcd_db), 0);
    chk("rst_hsync", 32'(lcd_hsync), 1);
    chk("rst_vsync", 32'(lcd_vsync), 1);
    chk("rst_pix_req", 32'(pix_req), 0);
    chk("rst_frame_start", 32'(frame_start), 0);
    chk("rst_line_start", 32'(line_start), 0);
    chk("rst_running", 32'(running), 0);
    rst = 1'b0;
    bad = 0; req1 = 0; dot1 = 0;
    repeat (300) begin
      @(negedge clk_50mhz);
      if (!rst_vals()) bad++;
      if (pix_req) req1++;
      if (lcd_dotclk) dot1++;
    end
    chk("idle_outputs", 32'(bad), 0);
    chk("idle_pix_req", 32'(req1), 0);
    chk("idle_dotclk", 32'(dot1), 0);
    enable = 1'b1;
    nfs = 0; nls = 0; hs_lo = 0; vs_lo = 0; de = 0; rises = 0; ncap = 0;
    bad_fs = 0; bad_ls = 0; bad_de = 0; bad_dot = 0; bad_db = 0;
    pdot = 1'b0; pdb = '0;
    for (int k = 0; k < 792; k++) begin
      @(negedge clk_50mhz);
      if (frame_start) begin nfs++; if (k % 264 != 0) bad_fs++; end
      if (line_start) begin nls++; if (k % 44 != 0) bad_ls++; end
      if (!lcd_hsync) hs_lo++;
      if (!lcd_vsync) vs_lo++;
      if (lcd_data_en) begin
        de++;
        if (((k - 2) % 264) / 44 < 2 || ((k - 2) % 264) / 44 > 4) bad_de++;
      end
      if (lcd_dotclk && !pdot) begin
        rises++;
        if (k % 4 != 3) bad_dot++;
        if (lcd_data_en && ncap < 36) begin cap[ncap] = lcd_db; ncap++; end
      end
      if (lcd_db !== pdb && k % 4 != 2) bad_db++;
      if (k == 104) begin
        chk("req_first", 32'(pix_req), 1);
        chk("pix_x_first", 32'(pix_x), 0);
        chk("pix_y_first", 32'(pix_y), 0);
      end
      if (k == 160) begin
        chk("pix_x_3_1", 32'(pix_x), 3);
        chk("pix_y_3_1", 32'(pix_y), 1);
      end
      pdot = lcd_dotclk;
      pdb = lcd_db;
      if (k == 527) border_en = 1'b1;
    end
    chk("frame_start_count", 32'(nfs), 3);
    chk("frame_start_spacing", 32'(bad_fs), 0);
    chk("line_start_count", 32'(nls), 18);
    chk("line_start_spacing", 32'(bad_ls), 0);
    chk("hsync_low_clks", 32'(hs_lo), 144);
    chk("vsync_low_clks", 32'(vs_lo), 132);
    chk("data_en_clks", 32'(de), 144);
    chk("data_en_lines", 32'(bad_de), 0);
    chk("dotclk_rises", 32'(rises), 198);
    chk("dotclk_period", 32'(bad_dot), 0);
    chk("db_setup", 32'(bad_db), 0);
    chk("db_capture_count", 32'(ncap), 36);
    for (int i = 0; i < 36; i++) begin
      exp_db = 18'((i % 12 / 4) * 512 + (i % 4));
      if (i >= 24 && (i % 4 == 0 || i % 4 == 3 || i % 12 / 4 == 0 || i % 12 / 4 == 2))
        exp_db = 18'h3FFFF;
      chk($sformatf("db_f%0d_x%0d_y%0d", i / 12, i % 4, i % 12 / 4), 32'(cap[i]), 32'(exp_db));
    end
    border_en = 1'b0;
    run_bad = 0; fs_bad = 0;
    for (int k = 792; k < 1060; k++) begin
      @(negedge clk_50mhz);
      if (k == 792) chk("fs_frame4", 32'(frame_start), 1);
      if (k > 792 && frame_start) fs_bad++;
      if (k < 1056 && !running) run_bad++;
      if (k == 1055) chk("stop_no_partial_dotclk", 32'(lcd_dotclk), 0);
      if (k == 1056) begin
        chk("stop_idle_outputs", 32'(rst_vals()), 1);
        chk("stop_running", 32'(running), 0);
      end
      if (k == 932) enable = 1'b0;
      if (k == 1059) enable = 1'b1;
    end
    chk("stop_running_held", 32'(run_bad), 0);
    chk("stop_no_frame_start", 32'(fs_bad), 0);
    run_bad = 0; fs_bad = 0;
    for (int k = 1060; k <= 1432; k++) begin
      @(negedge clk_50mhz);
      if (k == 1060) chk("fs_restart", 32'(frame_start), 1);
      if (k > 1060 && k < 1324 && frame_start) fs_bad++;
      if (!running) run_bad++;
      if (k == 1324) chk("fs_after_reassert", 32'(frame_start), 1);
      if (k == 1432) chk("req_before_rst", 32'(pix_req), 1);
      if (k == 1200) enable = 1'b0;
      if (k == 1260) enable = 1'b1;
    end
    chk("reassert_running", 32'(run_bad), 0);
    chk("reassert_no_early_fs", 32'(fs_bad), 0);
    rst = 1'b1;
    @(negedge clk_50mhz);
    chk("midrst_outputs", 32'(rst_vals()), 1);
    chk("midrst_pix_req", 32'(pix_req), 0);
    rst = 1'b0;
    @(negedge clk_50mhz);
    chk("fs_after_rst", 32'(frame_start), 1);
    chk("running_after_rst", 32'(running), 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
